ahb_arbiter: RTL and testbench

// - 16-master AHB bus arbiter between the masters' HBUSREQx/HLOCKx and the address/data mux select.
// - Grants at most one master per cycle using round-robin with lock hold and split masking.
// - Registers HMASTER/HMASTLOCK at each completed transfer (HREADY high).

---
 rtl/ahb_arbiter.sv | 115 +++++++++++
 tb/tb_ahb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Round-robin AHB bus arbiter for 16 masters. It grants at most one master
// per cycle. A master holding a locked transfer keeps the bus while it still
// requests it, and split masters are never eligible. HMASTER and HMASTLOCK
// change only at a completed transfer (HREADY high).
//
// Ports
//   HCLK       in   1   bus clock, all state changes on the rising edge
//   HRESETn    in   1   synchronous reset, active HIGH (resets when 1)
//   HBUSREQx   in   16  bus request, bit x = master x
//   HLOCKx     in   16  locked-transfer request, bit x = master x
//   HGRANTx    out  16  registered grant, one-hot or all-zero
//   HSPLIT     in   16  split mask, bit x high = master x not eligible
//   HREADY     in   1   transfer-complete strobe
//   HMASTER    out  4   index of the current bus owner (registered)
//   HMASTLOCK  out  1   current owner holds a locked transfer (registered)
// ---------------------------------------------------------------------------
module ahb_arbiter (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [15:0] HBUSREQx,
    input  logic [15:0] HLOCKx,
    output logic [15:0] HGRANTx,
    input  logic [15:0] HSPLIT,
    input  logic        HREADY,
    output logic [3:0]  HMASTER,
    output logic        HMASTLOCK
);

    logic [3:0]  rr_ptr;       // most recently granted master
    logic [15:0] eligible;
    logic        lock_hold;
    logic [3:0]  rr_start;
    logic [31:0] elig_dbl;
    logic [15:0] elig_rot;
    logic        rr_found;
    logic [3:0]  rr_off;
    logic        win_valid;
    logic [3:0]  win_idx;
    logic        grant_any;
    logic [3:0]  grant_idx;

    assign eligible  = HBUSREQx & ~HSPLIT;
    assign lock_hold = HMASTLOCK & HBUSREQx[HMASTER] & ~HSPLIT[HMASTER];
    assign rr_start  = rr_ptr + 4'd1;

    // Rotate the eligible vector so bit 0 is the master just after rr_ptr;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    // NOTE: every signal assigned in an always_comb block gets a default at
    // the top, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        elig_dbl = {eligible, eligible} >> rr_start;
        elig_rot = elig_dbl[15:0];
        rr_found = 1'b0;
        rr_off   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (elig_rot[i]) begin
                rr_found = 1'b1;
                rr_off   = 4'(i);
            end
        end
    end

    always_comb begin
        win_valid = 1'b0;
        win_idx   = 4'd0;
        if (lock_hold) begin
            win_valid = 1'b1;
            win_idx   = HMASTER;
        end else if (rr_found) begin
            win_valid = 1'b1;
            win_idx   = rr_start + rr_off;   // wraps 15 -> 0 in 4 bits
        end
    end

    // Index of the currently granted master (grant is one-hot or zero).
    always_comb begin
        grant_any = |HGRANTx;
        grant_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (HGRANTx[i]) begin
                grant_idx = 4'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            HGRANTx   <= '0;
            HMASTER   <= 4'd0;
            HMASTLOCK <= 1'b0;
            rr_ptr    <= 4'd15;
        end else if (!HREADY) begin
            // Arbitration cycle: decide the next grant, owner holds.
            HGRANTx <= win_valid ? (16'h0001 << win_idx) : 16'h0000;
            if (win_valid) begin
                rr_ptr <= win_idx;
            end
        end else begin
            // Handover cycle: the granted master becomes the bus owner.
            HGRANTx <= '0;
            if (grant_any) begin
                HMASTER   <= grant_idx;
                HMASTLOCK <= HLOCKx[grant_idx] & HBUSREQx[grant_idx];
            end else begin
                HMASTLOCK <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Self-checking bench for ahb_arbiter: a reset phase with random inputs, a
// table of directed vectors with hand-derived expectations, then a random
// run compared cycle by cycle against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] HBUSREQx;
    logic [15:0] HLOCKx;
    logic [15:0] HGRANTx;
    logic [15:0] HSPLIT;
    logic        HREADY;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;

    always #5 HCLK = ~HCLK;

    ahb_arbiter dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQx  (HBUSREQx),
        .HLOCKx    (HLOCKx),
        .HGRANTx   (HGRANTx),
        .HSPLIT    (HSPLIT),
        .HREADY    (HREADY),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    typedef struct {
        logic        rst;
        logic [15:0] br;
        logic [15:0] lk;
        logic [15:0] sp;
        logic        rdy;
        logic [15:0] g;
        logic [3:0]  m;
        logic        l;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state: granted master (-1 = none), owner, lock, last winner.
    int m_grant;
    int m_master;
    int m_rr;
    bit m_lock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic [15:0] br, input logic [15:0] lk,
                                input logic [15:0] sp, input logic rdy, input logic [15:0] g,
                                input logic [3:0] m, input logic l);
        vec_t v;
        v.rst = rst; v.br = br; v.lk = lk; v.sp = sp; v.rdy = rdy;
        v.g = g; v.m = m; v.l = l;
        vecs.push_back(v);
    endfunction

    // Winner by the arbitration rules: lock hold first, else the first
    // eligible master walking forward from the last winner.
    function automatic int pick(input logic [15:0] br, input logic [15:0] sp);
        logic [15:0] elig;
        elig = br & ~sp;
        if (m_lock && br[m_master] && !sp[m_master]) return m_master;
        for (int k = 1; k <= 16; k++) begin
            if (elig[(m_rr + k) % 16]) return (m_rr + k) % 16;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic rst, input logic [15:0] br, input logic [15:0] lk,
                                       input logic [15:0] sp, input logic rdy);
        int w;
        if (rst) begin
            m_grant = -1; m_master = 0; m_lock = 1'b0; m_rr = 15;
        end else if (!rdy) begin
            w = pick(br, sp);
            m_grant = w;
            if (w >= 0) m_rr = w;
        end else begin
            if (m_grant >= 0) begin
                m_master = m_grant;
                m_lock   = lk[m_grant] & br[m_grant];
            end else begin
                m_lock = 1'b0;
            end
            m_grant = -1;
        end
    endfunction

    // Apply one cycle of inputs, advance the model, and check the invariants.
    task automatic step(input logic rst, input logic [15:0] br, input logic [15:0] lk,
                        input logic [15:0] sp, input logic rdy);
        HRESETn  = rst;
        HBUSREQx = br;
        HLOCKx   = lk;
        HSPLIT   = sp;
        HREADY   = rdy;
        model_step(rst, br, lk, sp, rdy);
        @(posedge HCLK);
        #1;
        check("grant_onehot", 32'($countones(HGRANTx) <= 1), 32'd1);
        if (rdy) check("grant_low_after_ready", 32'(HGRANTx), 32'd0);
        check("grant_vs_split", 32'(HGRANTx & sp), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_g;

        HRESETn = 1'b1; HBUSREQx = '0; HLOCKx = '0; HSPLIT = '0; HREADY = 1'b0;

        // Reset held for two cycles under random inputs.
        repeat (2) step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        check("reset_grant",  32'(HGRANTx),   32'd0);
        check("reset_master", 32'(HMASTER),   32'd0);
        check("reset_lock",   32'(HMASTLOCK), 32'd0);

        //   rst   br        lk        sp        rdy   grant     mst   lock
        // Single request, then handover.
        add(1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0, 16'h0008, 4'd0, 1'b0);
        add(1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd3, 1'b0);
        // Round-robin from a fresh reset with 0x8003 held.
        add(1'b1, 16'h8003, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b0, 16'h0001, 4'd0, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b0, 16'h0002, 4'd0, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd1, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b0, 16'h8000, 4'd1, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd15, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b0, 16'h0001, 4'd15, 1'b0);
        add(1'b0, 16'h8003, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0);
        // Lock: master 1 first, then master 2 takes a locked transfer.
        add(1'b0, 16'h0006, 16'h0004, 16'h0000, 1'b0, 16'h0002, 4'd0, 1'b0);
        add(1'b0, 16'h0006, 16'h0004, 16'h0000, 1'b1, 16'h0000, 4'd1, 1'b0);
        add(1'b0, 16'h0006, 16'h0004, 16'h0000, 1'b0, 16'h0004, 4'd1, 1'b0);
        add(1'b0, 16'h0006, 16'h0004, 16'h0000, 1'b1, 16'h0000, 4'd2, 1'b1);
        add(1'b0, 16'h0006, 16'h0004, 16'h0000, 1'b0, 16'h0004, 4'd2, 1'b1);
        add(1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd2, 1'b0);
        add(1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b0, 16'h0002, 4'd2, 1'b0);
        add(1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'd1, 1'b0);
        // Split masking, then everything split, then a long idle handover.
        add(1'b0, 16'h0030, 16'h0000, 16'h0010, 1'b0, 16'h0020, 4'd1, 1'b0);
        add(1'b0, 16'h0030, 16'h0000, 16'h0010, 1'b1, 16'h0000, 4'd5, 1'b0);
        add(1'b0, 16'h0030, 16'h0000, 16'h0010, 1'b0, 16'h0020, 4'd5, 1'b0);
        add(1'b0, 16'h0030, 16'h0000, 16'h0010, 1'b1, 16'h0000, 4'd5, 1'b0);
        add(1'b0, 16'h0030, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 4'd5, 1'b0);
        add(1'b0, 16'h0030, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 4'd5, 1'b0);
        add(1'b0, 16'h0030, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 4'd5, 1'b0);
        add(1'b0, 16'h0030, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 4'd5, 1'b0);
        // Owner locked, then split: lock hold is bypassed, HMASTLOCK waits for handover.
        add(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0);
        add(1'b0, 16'h0004, 16'h0004, 16'h0000, 1'b0, 16'h0004, 4'd0, 1'b0);
        add(1'b0, 16'h0004, 16'h0004, 16'h0000, 1'b1, 16'h0000, 4'd2, 1'b1);
        add(1'b0, 16'h0006, 16'h0004, 16'h0004, 1'b0, 16'h0002, 4'd2, 1'b1);
        add(1'b0, 16'h0006, 16'h0004, 16'h0004, 1'b1, 16'h0000, 4'd1, 1'b0);
        // Request dropped: grant clears at the next arbitration edge.
        add(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd1, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].br, vecs[i].lk, vecs[i].sp, vecs[i].rdy);
            check($sformatf("vec%0d_grant", i),  32'(HGRANTx),   32'(vecs[i].g));
            check($sformatf("vec%0d_master", i), 32'(HMASTER),   32'(vecs[i].m));
            check($sformatf("vec%0d_lock", i),   32'(HMASTLOCK), 32'(vecs[i].l));
        end

        // Random run against the model; locks are frequent so hold is exercised.
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 63) == 0),
                 16'($urandom),
                 16'($urandom | $urandom),
                 16'($urandom & $urandom & $urandom),
                 1'($urandom));
            exp_g = (m_grant < 0) ? 16'h0000 : (16'h0001 << m_grant);
            check($sformatf("rand%0d_grant", c),  32'(HGRANTx),   32'(exp_g));
            check($sformatf("rand%0d_master", c), 32'(HMASTER),   32'(m_master));
            check($sformatf("rand%0d_lock", c),   32'(HMASTLOCK), 32'(m_lock));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
